// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared funct3 codes and requester ids for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational winner selection between core and debug requesters
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic core_req,
    input  logic dbg_req,
    input  logic wait_max,
    output logic grant,
    output logic winner
);

    req_id_t win_id;

    // Core has priority; debug only wins alone or after waiting the full budget.
    always_comb begin
        win_id = REQ_CORE;
        if (dbg_req && (!core_req || wait_max)) begin
            win_id = REQ_DBG;
        end
    end

    assign grant  = core_req | dbg_req;
    assign winner = win_id;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with bounded debug starvation
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_funct3,
    output logic                  core_gnt,
    output logic                  dbg_gnt,
    output logic                  core_rvalid,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     core_rdata,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_max;
    logic              any_grant;
    logic              winner;
    req_id_t           win_id;

    assign wait_max = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign win_id   = req_id_t'(winner);

    dmem_arb_pick u_pick (
        .core_req (core_req),
        .dbg_req  (dbg_req),
        .wait_max (wait_max),
        .grant    (any_grant),
        .winner   (winner)
    );

    // Reset gates the grant path directly so the memory sees nothing while rst is high.
    always_comb begin
        core_gnt   = 1'b0;
        dbg_gnt    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;
        mem_funct3 = '0;
        if (!rst && any_grant) begin
            if (win_id == REQ_DBG) begin
                dbg_gnt    = 1'b1;
                mem_read   = !dbg_we;
                mem_write  = dbg_we;
                mem_a      = dbg_addr;
                mem_wd     = dbg_wdata;
                mem_funct3 = dbg_funct3;
            end else begin
                core_gnt   = 1'b1;
                mem_read   = !core_we;
                mem_write  = core_we;
                mem_a      = core_addr;
                mem_wd     = core_wdata;
                mem_funct3 = core_funct3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (dbg_req && !dbg_gnt) begin
            if (!wait_max) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
            core_rdata  <= '0;
            dbg_rdata   <= '0;
        end else begin
            core_rvalid <= core_gnt && !core_we;
            dbg_rvalid  <= dbg_gnt && !dbg_we;
            if (core_gnt && !core_we) begin
                core_rdata <= mem_rd;
            end
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural reference
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [2:0]    core_funct3 = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [2:0]    dbg_funct3 = '0;
    logic          core_gnt, dbg_gnt, core_rvalid, dbg_rvalid;
    logic [DW-1:0] core_rdata, dbg_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rd;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_funct3(dbg_funct3),
        .core_gnt(core_gnt), .dbg_gnt(dbg_gnt),
        .core_rvalid(core_rvalid), .dbg_rvalid(dbg_rvalid),
        .core_rdata(core_rdata), .dbg_rdata(dbg_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a];
    always @(posedge clk) if (mem_write) mem[mem_a] <= mem_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: debug denied streak, and the load results owed next cycle.
    int            m_streak = 0;
    logic          m_crv = 1'b0, m_drv = 1'b0;
    logic [DW-1:0] m_crd = '0, m_drd = '0;
    logic          m_dg, m_cg;

    function automatic logic dbg_wins();
        return dbg_req && (!core_req || m_streak >= MW);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_streak = 0;
            m_crv = 1'b0; m_drv = 1'b0;
            m_crd = '0;   m_drd = '0;
        end else begin
            m_dg  = dbg_wins();
            m_cg  = core_req && !m_dg;
            m_crv = m_cg && !core_we;
            m_drv = m_dg && !dbg_we;
            if (m_crv) m_crd = mem[core_addr];
            if (m_drv) m_drd = mem[dbg_addr];
            if (dbg_req && !m_dg) m_streak = (m_streak < MW) ? m_streak + 1 : MW;
            else m_streak = 0;
        end
    end

    always @(negedge clk) begin
        logic e_dg, e_cg;
        e_dg = !rst && dbg_wins();
        e_cg = !rst && core_req && !e_dg;
        chk("core_gnt", core_gnt, e_cg);
        chk("dbg_gnt", dbg_gnt, e_dg);
        chk("mem_read", mem_read, (e_cg && !core_we) || (e_dg && !dbg_we));
        chk("mem_write", mem_write, (e_cg && core_we) || (e_dg && dbg_we));
        chk("mem_a", mem_a, e_dg ? dbg_addr : (e_cg ? core_addr : '0));
        chk("mem_wd", mem_wd, e_dg ? dbg_wdata : (e_cg ? core_wdata : '0));
        chk("mem_funct3", mem_funct3, e_dg ? dbg_funct3 : (e_cg ? core_funct3 : '0));
        chk("core_rvalid", core_rvalid, m_crv);
        chk("dbg_rvalid", dbg_rvalid, m_drv);
        chk("core_rdata", core_rdata, m_crd);
        chk("dbg_rdata", dbg_rdata, m_drd);
    end

    task automatic idle();
        core_req = 1'b0; dbg_req = 1'b0;
        core_we = 1'b0;  dbg_we = 1'b0;
    endtask

    logic [11:0] pattern;
    int          wait_cycles;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 32'h0101_0003);
        mem[1] = 32'hFFFF_FFF8;

        #3;
        chk("reset_core_gnt", core_gnt, 1'b0);
        chk("reset_rdata", core_rdata, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Core word load from address 1.
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h001; core_funct3 = F3_LW;
        #3 chk("ld_core_gnt", core_gnt, 1'b1);
        @(posedge clk); #1 idle();
        #3;
        chk("ld_core_rvalid", core_rvalid, 1'b1);
        chk("ld_core_rdata", core_rdata, 32'hFFFF_FFF8);
        chk("ld_dbg_rvalid", dbg_rvalid, 1'b0);

        // Debug store then load of the same word, back to back.
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h004;
        dbg_wdata = 32'h1234_5678; dbg_funct3 = F3_SW;
        #3 chk("st_mem_write", mem_write, 1'b1);
        @(posedge clk); #1;
        dbg_we = 1'b0; dbg_funct3 = F3_LW;
        #3 chk("st_no_rvalid", dbg_rvalid, 1'b0);
        @(posedge clk); #1 idle();
        #3;
        chk("dbg_rvalid", dbg_rvalid, 1'b1);
        chk("dbg_rdata", dbg_rdata, 32'h1234_5678);

        // Idle cycle: memory port quiet.
        @(posedge clk); #1;
        #3;
        chk("idle_mem_read", mem_read, 1'b0);
        chk("idle_mem_a", mem_a, '0);
        chk("idle_rvalid", core_rvalid | dbg_rvalid, 1'b0);

        // Continuous contention for 12 cycles.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            core_req = 1'b1; core_addr = 9'h002;
            dbg_req = 1'b1;  dbg_addr = 9'h003;
            #3 pattern[i] = dbg_gnt;
        end
        chk("contention_pattern", pattern, 12'h210);
        @(posedge clk); #1 idle();

        // Debug gives up after 2 denied cycles, then re-requests.
        @(posedge clk); #1;
        core_req = 1'b1; dbg_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 dbg_req = 1'b0;
        @(posedge clk); #1 dbg_req = 1'b1;
        wait_cycles = -1;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (dbg_gnt) begin
                wait_cycles = i;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rerequest_wait", wait_cycles, 4);
        @(posedge clk); #1 idle();

        // Reset in the middle of a granted core load.
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h001;
        #2 rst = 1'b1;
        #1;
        chk("rst_core_gnt", core_gnt, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        #3;
        chk("rst_core_rvalid", core_rvalid, 1'b0);
        chk("rst_core_rdata", core_rdata, '0);
        chk("rst_dbg_rdata", dbg_rdata, '0);

        // Normal arbitration right after release.
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h001;
        #3 chk("post_rst_dbg_gnt", dbg_gnt, 1'b1);
        @(posedge clk); #1 idle();
        #3 chk("post_rst_dbg_rdata", dbg_rdata, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
